// File: rtl/conv_pkg.sv
// conv_pkg: shared element/row size defaults, counter width helper
// and serializer FSM states for the convolution row serializer.
package conv_pkg;

  localparam int data_size_def      = 4;
  localparam int max_width_def      = 9;
  localparam int row_fifo_depth_def = 4;

  // bits needed to hold the values 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/conv_row_serializer_row_fifo.sv
// row_fifo: synchronous FIFO of {row_width, row_data} words.
// Ports: push/push_data in, pop/pop_data out, full/empty/count status.
module row_fifo
  import conv_pkg::*;
#(
  parameter int width = 40,
  parameter int depth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [width-1:0]        push_data,
  input  logic                    pop,
  output logic [width-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(depth)-1:0] count
);

  localparam int aw = $clog2(depth);
  localparam int cw = cnt_w(depth);
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == full_cnt);
  assign empty    = (count == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // depth is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_row_serializer.sv
// conv_row_serializer: buffers packed rows (element 0 in MSBs) in a
// row FIFO and streams them out one element per valid/ready beat.
// Ports: clk, reset (sync, high), enable; row side row_valid/
// row_ready/row_data/row_width; element side elem_data/elem_valid/
// elem_ready/elem_last; rows_pending = FIFO occupancy.
// Optional CONV_ROW_SER_OVERFLOW_EN adds sticky output overflow.
module conv_row_serializer
  import conv_pkg::*;
#(
  parameter int data_size              = data_size_def,
  parameter int max_input_matrix_width = max_width_def,
  parameter int row_fifo_depth         = row_fifo_depth_def
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic row_valid,
  output logic row_ready,
  input  logic [data_size*max_input_matrix_width-1:0] row_data,
  input  logic [cnt_w(max_input_matrix_width)-1:0]    row_width,
  output logic [data_size-1:0] elem_data,
  output logic elem_valid,
  input  logic elem_ready,
  output logic elem_last,
  output logic [cnt_w(row_fifo_depth)-1:0] rows_pending
`ifdef CONV_ROW_SER_OVERFLOW_EN
  ,
  output logic overflow
`endif
);

  localparam int rw = data_size * max_input_matrix_width;
  localparam int ww = cnt_w(max_input_matrix_width);
  localparam int fw = ww + rw;
  localparam logic [ww-1:0] max_w = ww'(max_input_matrix_width);
  localparam logic [ww-1:0] one_w = ww'(1);

  ser_state_t    state;
  logic [rw-1:0] shift_q;
  logic [ww-1:0] cnt_q;
  logic [ww-1:0] width_c;
  logic [fw-1:0] pop_word;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign row_ready = enable && !fifo_full;
  assign width_c   = (row_width > max_w) ? max_w : row_width;
  // zero-width rows complete the handshake but are never stored
  assign push      = row_valid && row_ready && (row_width != '0);

  assign elem_data = shift_q[rw-1 -: data_size];
  assign elem_last = (cnt_q == one_w);

  // cnt_q is 0 in IDLE, so elem_last alone marks the final beat
  assign pop = !fifo_empty &&
               ((state == IDLE) || (elem_ready && elem_last));

  row_fifo #(
    .width (fw),
    .depth (row_fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({width_c, row_data}),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rows_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      elem_valid <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift_q    <= pop_word[rw-1:0];
            cnt_q      <= pop_word[fw-1:rw];
            elem_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (elem_ready) begin
            if (!elem_last) begin
              shift_q <= shift_q << data_size;
              cnt_q   <= cnt_q - 1'b1;
            end else if (pop) begin
              // next row follows with no idle beat
              shift_q <= pop_word[rw-1:0];
              cnt_q   <= pop_word[fw-1:rw];
            end else begin
              shift_q    <= '0;
              cnt_q      <= '0;
              elem_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_ROW_SER_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (row_valid && enable && fifo_full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_row_serializer.sv
// tb_conv_row_serializer: scoreboard bench for conv_row_serializer,
// directed scenarios plus randomized rows and backpressure.
module tb_conv_row_serializer;

  localparam int DW = 4;
  localparam int MW = 9;
  localparam int RW = DW * MW;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          row_valid;
  logic          row_ready;
  logic [RW-1:0] row_data;
  logic [3:0]    row_width;
  logic [3:0]    elem_data;
  logic          elem_valid;
  logic          elem_ready;
  logic          elem_last;
  logic [2:0]    rows_pending;
`ifdef CONV_ROW_SER_OVERFLOW_EN
  logic          overflow;
`endif

  int    tests = 0;
  int    fails = 0;
  int    ready_mode = 3;
  beat_t exp_q[$];
  logic [3:0] el [MW];

  always #5 clk = ~clk;

  conv_row_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_data     (row_data),
    .row_width    (row_width),
    .elem_data    (elem_data),
    .elem_valid   (elem_valid),
    .elem_ready   (elem_ready),
    .elem_last    (elem_last),
    .rows_pending (rows_pending)
`ifdef CONV_ROW_SER_OVERFLOW_EN
    ,
    .overflow     (overflow)
`endif
  );

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [3:0] e [MW]);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < MW; i++) r[RW-1-DW*i -: DW] = e[i];
    return r;
  endfunction

  task automatic rand_el();
    for (int i = 0; i < MW; i++) el[i] = 4'($urandom_range(0, 15));
  endtask

  // drive a row until accepted; expected beats enter the scoreboard
  task automatic send_row(input logic [3:0] e [MW], input int w);
    int n;
    int eff;
    row_data  = pack(e);
    row_width = 4'(w);
    row_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (row_ready) break;
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL push_timeout: row_ready got 0 expected 1");
        row_valid = 1'b0;
        return;
      end
    end
    eff = (w > MW) ? MW : w;
    for (int i = 0; i < eff; i++) begin
      beat_t b;
      b.d = e[i];
      b.l = (i == eff - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    row_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !elem_valid) break;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_idle", elem_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    beat_t      b;
    logic       hold;
    logic [3:0] hd;
    logic       hl;
    hold = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_valid", elem_valid, 1);
        check("hold_data", elem_data, hd);
        check("hold_last", elem_last, hl);
      end
      hold = 1'b0;
      if (elem_valid) begin
        if (elem_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat: got data %0h expected none",
                     elem_data);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", elem_data, b.d);
            check("beat_last", elem_last, b.l);
          end
        end else begin
          hold = 1'b1;
          hd   = elem_data;
          hl   = elem_last;
        end
      end
    end
  endtask

  // acts at +2 so mode changes made at +1 take effect this cycle
  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: elem_ready = 1'b1;
        1: elem_ready = ~elem_ready;
        2: elem_ready = 1'($urandom_range(0, 1));
        3: elem_ready = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic fill_five();
    ready_mode = 3;
    @(posedge clk);
    #1;
    for (int r = 0; r < 5; r++) begin
      rand_el();
      send_row(el, 3);
    end
  endtask

  initial begin
    int gap;
    reset      = 1'b1;
    enable     = 1'b1;
    row_valid  = 1'b0;
    row_data   = '0;
    row_width  = '0;
    elem_ready = 1'b0;
    fork
      monitor();
      ready_drv();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", elem_valid, 0);
    check("rst_data", elem_data, 0);
    check("rst_last", elem_last, 0);
    check("rst_pending", rows_pending, 0);
    check("rst_row_ready", row_ready, 1);
`ifdef CONV_ROW_SER_OVERFLOW_EN
    check("rst_overflow", overflow, 0);
`endif
    reset = 1'b0;

    // 1: latency and a full-width row
    ready_mode = 0;
    for (int i = 0; i < MW; i++) el[i] = 4'(i + 1);
    send_row(el, 9);
    check("lat_n_valid", elem_valid, 0);
    check("lat_n_pending", rows_pending, 1);
    @(posedge clk);
    #1;
    check("lat_n1_valid", elem_valid, 1);
    check("lat_n1_data", elem_data, 1);
    check("lat_n1_pending", rows_pending, 0);
    wait_drain();

    // 2: width 7 with toggling ready
    ready_mode = 1;
    el[0] = 4'hA; el[1] = 4'hB; el[2] = 4'hC; el[3] = 4'hD;
    el[4] = 4'hE; el[5] = 4'hF; el[6] = 4'h1; el[7] = 4'h5;
    el[8] = 4'h5;
    send_row(el, 7);
    wait_drain();

    // 3: fill FIFO under stall, then release without bubbles
    fill_five();
    check("full_row_ready", row_ready, 0);
    check("full_pending", rows_pending, 4);
    check("full_valid", elem_valid, 1);
    @(posedge clk);
    #1;
    check("full_hold_ready", row_ready, 0);
    ready_mode = 0;
    gap = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (!(elem_valid && elem_ready)) gap++;
      if (i == 2) check("pop_edge_ready", row_ready, 0);
      if (i == 3) check("after_pop_ready", row_ready, 1);
    end
    check("no_bubble", gap, 0);
    wait_drain();

    // 4: zero width, then clamped width
    rand_el();
    send_row(el, 0);
    check("w0_pending", rows_pending, 0);
    check("w0_valid", elem_valid, 0);
    rand_el();
    send_row(el, 12);
    wait_drain();

    // 5: reset in the middle of a row
    ready_mode = 4;
    elem_ready = 1'b0;
    rand_el();
    send_row(el, 9);
    @(posedge clk);
    #1;
    check("mid_valid", elem_valid, 1);
    elem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    elem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", elem_valid, 0);
    check("mid_rst_pending", rows_pending, 0);
    check("mid_rst_data", elem_data, 0);
    check("mid_rst_last", elem_last, 0);
    ready_mode = 0;
    rand_el();
    send_row(el, 5);
    wait_drain();

    // 6: refused pushes on a full FIFO
    fill_five();
    row_valid = 1'b1;
    row_width = 4'd4;
    row_data  = RW'({$urandom(), $urandom()});
    @(negedge clk);
    check("ovf_row_ready", row_ready, 0);
    @(posedge clk);
    #1;
    row_valid = 1'b0;
`ifdef CONV_ROW_SER_OVERFLOW_EN
    check("ovf_set", overflow, 1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_sticky", overflow, 1);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
`ifdef CONV_ROW_SER_OVERFLOW_EN
    check("ovf_rst", overflow, 0);
`endif
    fill_five();
    enable    = 1'b0;
    row_valid = 1'b1;
    @(negedge clk);
    check("dis_row_ready", row_ready, 0);
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    enable    = 1'b1;
`ifdef CONV_ROW_SER_OVERFLOW_EN
    check("ovf_disabled", overflow, 0);
`endif
    ready_mode = 0;
    wait_drain();

    // random rows, widths and backpressure
    ready_mode = 2;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        enable    = 1'b0;
        row_valid = 1'b1;
        row_width = 4'd3;
        @(negedge clk);
        check("rand_enable_gate", row_ready, 0);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        enable    = 1'b1;
      end
      rand_el();
      send_row(el, int'($urandom_range(0, 12)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
